// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   localparam int unsigned REG_W = 5;
   localparam int unsigned FWD_W_BITS = 2;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      I_WAIT  = 2'd1,
      D_WAIT  = 2'd2,
      ID_WAIT = 2'd3
   } mem_wait_e;

   localparam logic [FWD_W_BITS-1:0] FWD_RF = 2'b00;
   localparam logic [FWD_W_BITS-1:0] FWD_W  = 2'b01;
   localparam logic [FWD_W_BITS-1:0] FWD_M  = 2'b10;

   // Register zero is hardwired, so it never participates in a hazard.
   function automatic logic reg_match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
      return (a != '0) && (a == b);
   endfunction

endpackage

// File: rtl/fwd_sel.sv
// Execute-stage forward select for one source operand; M result beats W result.
module fwd_sel
   import hazard_pkg::*;
(
   input  logic [REG_W-1:0]      src_i,
   input  logic [REG_W-1:0]      write_reg_m_i,
   input  logic                  reg_write_m_i,
   input  logic [REG_W-1:0]      write_reg_w_i,
   input  logic                  reg_write_w_i,
   output logic [FWD_W_BITS-1:0] fwd_o
);

   always_comb begin
      fwd_o = FWD_RF;
      if (reg_write_m_i && reg_match(write_reg_m_i, src_i)) begin
         fwd_o = FWD_M;
      end else if (reg_write_w_i && reg_match(write_reg_w_i, src_i)) begin
         fwd_o = FWD_W;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and cache-miss stall controller for the 5-stage pipeline,
// with a registered refill-wait FSM and a stall-cycle counter.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [REG_W-1:0]      rs_d_i,
   input  logic [REG_W-1:0]      rt_d_i,
   input  logic [1:0]            branch_d_i,
   input  logic                  jr_d_i,
   input  logic [REG_W-1:0]      rs_e_i,
   input  logic [REG_W-1:0]      rt_e_i,
   input  logic [REG_W-1:0]      write_reg_e_i,
   input  logic                  reg_write_e_i,
   input  logic                  mem_to_reg_e_i,
   input  logic [REG_W-1:0]      write_reg_m_i,
   input  logic                  reg_write_m_i,
   input  logic                  mem_to_reg_m_i,
   input  logic [REG_W-1:0]      write_reg_w_i,
   input  logic                  reg_write_w_i,
   input  logic                  i_miss_i,
   input  logic                  i_done_i,
   input  logic                  d_miss_i,
   input  logic                  d_done_i,
   output logic                  stall_f_o,
   output logic                  stall_d_o,
   output logic                  stall_e_o,
   output logic                  stall_m_o,
   output logic                  flush_e_o,
   output logic                  flush_w_o,
   output logic                  forward_a_d_o,
   output logic                  forward_b_d_o,
   output logic [FWD_W_BITS-1:0] forward_a_e_o,
   output logic [FWD_W_BITS-1:0] forward_b_e_o,
   output logic [CNT_W-1:0]      stall_cnt_o
);

   mem_wait_e               state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [FWD_W_BITS-1:0]   fwd_a_e, fwd_b_e;
   logic                    lw_stall, br_stall, fetch_stall, mem_stall;
   logic                    hit_e_rs, hit_e_rt, hit_m_rs, hit_m_rt;

   fwd_sel u_fwd_a (
      .src_i         (rs_e_i),
      .write_reg_m_i (write_reg_m_i),
      .reg_write_m_i (reg_write_m_i),
      .write_reg_w_i (write_reg_w_i),
      .reg_write_w_i (reg_write_w_i),
      .fwd_o         (fwd_a_e)
   );

   fwd_sel u_fwd_b (
      .src_i         (rt_e_i),
      .write_reg_m_i (write_reg_m_i),
      .reg_write_m_i (reg_write_m_i),
      .write_reg_w_i (write_reg_w_i),
      .reg_write_w_i (reg_write_w_i),
      .fwd_o         (fwd_b_e)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, hazard detection and stage controls; reset forces every control low.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      stall_f_o     = 1'b0;
      stall_d_o     = 1'b0;
      stall_e_o     = 1'b0;
      stall_m_o     = 1'b0;
      flush_e_o     = 1'b0;
      flush_w_o     = 1'b0;
      forward_a_d_o = 1'b0;
      forward_b_d_o = 1'b0;
      forward_a_e_o = FWD_RF;
      forward_b_e_o = FWD_RF;

      unique case (state_q)
         RUN: begin
            if (d_miss_i && i_miss_i) state_d = ID_WAIT;
            else if (d_miss_i)        state_d = D_WAIT;
            else if (i_miss_i)        state_d = I_WAIT;
         end
         I_WAIT: begin
            if (i_done_i && d_miss_i) state_d = D_WAIT;
            else if (i_done_i)        state_d = RUN;
            else if (d_miss_i)        state_d = ID_WAIT;
         end
         D_WAIT: begin
            if (d_done_i) state_d = RUN;
         end
         ID_WAIT: begin
            if (i_done_i && d_done_i) state_d = RUN;
            else if (d_done_i)        state_d = I_WAIT;
            else if (i_done_i)        state_d = D_WAIT;
         end
         default: state_d = RUN;
      endcase

      hit_e_rs = reg_match(write_reg_e_i, rs_d_i);
      hit_e_rt = reg_match(write_reg_e_i, rt_d_i);
      hit_m_rs = reg_match(write_reg_m_i, rs_d_i);
      hit_m_rt = reg_match(write_reg_m_i, rt_d_i);

      lw_stall = mem_to_reg_e_i && (hit_e_rs || hit_e_rt);
      // jr only reads rs, so rt hazards are ignored for it.
      br_stall = ((branch_d_i != 2'b00) &&
                  ((reg_write_e_i && (hit_e_rs || hit_e_rt)) ||
                   (mem_to_reg_m_i && (hit_m_rs || hit_m_rt)))) ||
                 (jr_d_i && ((reg_write_e_i && hit_e_rs) || (mem_to_reg_m_i && hit_m_rs)));

      mem_stall   = d_miss_i || (state_q == D_WAIT) || (state_q == ID_WAIT);
      fetch_stall = i_miss_i || (state_q == I_WAIT) || (state_q == ID_WAIT);

      if (!rst_i) begin
         stall_f_o     = lw_stall || br_stall || fetch_stall || mem_stall;
         stall_d_o     = stall_f_o;
         stall_e_o     = mem_stall;
         stall_m_o     = mem_stall;
         flush_w_o     = mem_stall;
         flush_e_o     = (lw_stall || br_stall || fetch_stall) && !mem_stall;
         forward_a_d_o = reg_write_m_i && hit_m_rs;
         forward_b_d_o = reg_write_m_i && hit_m_rt;
         forward_a_e_o = fwd_a_e;
         forward_b_e_o = fwd_b_e;
      end

      if (stall_f_o) cnt_d = cnt_q + CNT_W'(1);
   end

   assign stall_cnt_o = cnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and memory-stall controller for the 5-stage MIPS core. It generates stall, flush and forwarding selects for the fetch, decode, execute, memory and writeback pipeline registers. It resolves register hazards from pipeline state, and it sequences I-cache and D-cache miss refills with a registered wait FSM. A 32-bit stall-cycle counter is exported for performance monitoring.

## Interface
Parameters:
- CNT_W, 32, stall-cycle counter width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- rs_d_i, rt_d_i  in  5 each  source registers in D
- branch_d_i  in  2  branch type in D (nonzero = branch)
- jr_d_i  in  1  register-indirect jump in D (uses rs only)
- rs_e_i, rt_e_i, write_reg_e_i  in  5 each  E-stage register numbers
- reg_write_e_i, mem_to_reg_e_i  in  1 each  E-stage controls
- write_reg_m_i  in  5, reg_write_m_i / mem_to_reg_m_i  in  1 each  M-stage
- write_reg_w_i  in  5, reg_write_w_i  in  1  W-stage
- i_miss_i  in  1  I-cache miss for current fetch (level)
- i_done_i  in  1  I-cache refill complete (1-cycle pulse)
- d_miss_i  in  1  D-cache miss for current M access (level)
- d_done_i  in  1  D-cache refill complete (1-cycle pulse)
- stall_f_o, stall_d_o, stall_e_o, stall_m_o  out  1 each  hold the stage register
- flush_e_o, flush_w_o  out  1 each  insert a bubble
- forward_a_d_o, forward_b_d_o  out  1 each  select ALU-out-M in D
- forward_a_e_o, forward_b_e_o  out  2 each  00 regfile, 01 result W, 10 ALU-out M
- stall_cnt_o  out  CNT_W  stall cycles since reset

## Operation
- Register zero never matches in any comparison.
- forward_a_e_o:
  - 10 when reg_write_m & write_reg_m==rs_e.
  - else 01 when reg_write_w & write_reg_w==rs_e.
  - else 00.
  - forward_b_e_o is the same using rt_e. M has priority over W.
- forward_a_d_o = reg_write_m & write_reg_m==rs_d. forward_b_d_o uses rt_d.
- lw_stall = mem_to_reg_e & write_reg_e ∈ {rs_d, rt_d}.
- br_stall applies when branch_d≠0 (compares rs_d and rt_d) or jr_d (compares rs_d only). It asserts when either condition holds:
  - reg_write_e & write_reg_e matches a compared source.
  - mem_to_reg_m & write_reg_m matches a compared source.
- Memory-wait FSM has states RUN, I_WAIT, D_WAIT, ID_WAIT.
  - RUN:
    - d_miss & i_miss → ID_WAIT.
    - d_miss → D_WAIT.
    - i_miss → I_WAIT.
  - I_WAIT:
    - i_done & d_miss → D_WAIT.
    - i_done → RUN.
    - d_miss → ID_WAIT.
  - D_WAIT: d_done → RUN.
  - ID_WAIT:
    - Both done in the same cycle → RUN.
    - d_done only → I_WAIT.
    - i_done only → D_WAIT.
- mem_stall = d_miss | state∈{D_WAIT, ID_WAIT}.
- fetch_stall = i_miss | state∈{I_WAIT, ID_WAIT}.
- Stage outputs:
  - stall_f_o = stall_d_o = lw_stall | br_stall | fetch_stall | mem_stall.
  - stall_e_o = stall_m_o = mem_stall.
  - flush_w_o = mem_stall.
  - flush_e_o = (lw_stall | br_stall | fetch_stall) & ~mem_stall. Stall wins over flush on the E register.
- stall_cnt_o increments by 1 in every cycle in which stall_f_o is 1. It wraps modulo 2^CNT_W.

## Timing
- Forward, stall and flush outputs are combinational from the inputs and the registered state, with zero-cycle latency. Only the state and stall_cnt_o are registered.
- FSM transitions occur on the rising clk_i edge following the event.
- A done pulse in a state that is not waiting for it is ignored.
- Exit latency after a refill:
  - The done pulse cycle is still stalled.
  - The stage advances in the next cycle, provided the cache reports a hit (miss=0).
  - A repeated miss re-enters the wait state.
- While rst_i is high:
  - State = RUN and stall_cnt_o = 0.
  - All stall, flush and forward outputs are forced to 0 regardless of inputs.
- Reset asserted mid-wait aborts the wait immediately. After deassertion the FSM is in RUN.

## Structure
- hazard_pkg holds:
  - The state enum mem_wait_e {RUN, I_WAIT, D_WAIT, ID_WAIT}.
  - Forward-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
- Sub-module fwd_sel: priority comparator producing one 2-bit E forward select. It is instantiated twice, for rs_e and rt_e.

## Test plan
- RAW on ALU result: write_reg_m=8, reg_write_m=1, rs_e=8, write_reg_w=8, reg_write_w=1 → forward_a_e_o=10. With reg_write_m=0 → 01. With rs_e=0 → 00.
- Load-use: mem_to_reg_e=1, write_reg_e=9, rt_d=9 → stall_f/d=1, flush_e=1, stall_e=0. Exactly one stall cycle after E advances.
- Branch after ALU op: branch_d=01, rs_d=5, reg_write_e=1, write_reg_e=5 → stall_f/d=1, flush_e=1. jr_d=1 with rt_d=5 only → no stall.
- I-miss: i_miss=1 for 10 cycles, then i_done pulse → I_WAIT, stall_f/d=1, flush_e=1, stall_e=0. RUN after the pulse. stall_cnt_o advances by 11.
- Overlapping misses: i_miss and d_miss together → ID_WAIT, stall_e/m=1, flush_w=1, flush_e=0.
  - d_done → I_WAIT, then i_done → RUN.
  - Also check both done pulses in the same cycle → RUN.
- Reset mid D_WAIT: assert rst_i → all outputs 0 and stall_cnt_o=0 asynchronously. After release with no misses, state is RUN.
